// File: rtl/digit_unit.sv
// rtl/digit_unit.sv - sequential decimal-digit read/write engine for dgt and dst
// Decomposes |acc| by repeated subtraction, then returns or replaces one digit.
module digit_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [10:0] acc,
    input  logic [10:0] arg1,
    input  logic [10:0] arg2,
    output logic        busy,
    output logic        done,
    output logic [10:0] out
);

    typedef enum logic [1:0] {IDLE, HUND, TENS, FINISH} state_t;

    state_t      state, state_next;
    logic        op_r, sgn_r, neg2_r, idx_ok_r;
    logic [1:0]  idx_r;
    logic [3:0]  v_r, h, t, u;
    logic [9:0]  mag;

    logic [11:0] acc_ext, acc_abs, a2_ext, a2_abs;
    logic [9:0]  mag_load;
    logic [3:0]  v_load;
    logic        idx_ok_load;

    logic [3:0]  dh, dt, du, digit;
    logic [9:0]  m;
    logic        neg;
    logic [10:0] res;

    // Operand conditioning at acceptance; 12 bits so that |-1024| does not wrap.
    always_comb begin
        acc_ext     = {acc[10], acc};
        acc_abs     = acc[10] ? 12'(-acc_ext) : acc_ext;
        mag_load    = (acc_abs > 12'd999) ? 10'd999 : acc_abs[9:0];
        a2_ext      = {arg2[10], arg2};
        a2_abs      = arg2[10] ? 12'(-a2_ext) : a2_ext;
        v_load      = (a2_abs > 12'd9) ? 4'd9 : a2_abs[3:0];
        idx_ok_load = (arg1 < 11'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = HUND;
            HUND:    if (mag < 10'd100) state_next = TENS;
            TENS:    if (mag < 10'd10) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        dh   = h;
        dt   = t;
        du   = u;
        if (idx_ok_r) begin
            case (idx_r)
                2'd0:    du = v_r;
                2'd1:    dt = v_r;
                default: dh = v_r;
            endcase
        end
        case (idx_r)
            2'd0:    digit = u;
            2'd1:    digit = t;
            default: digit = h;
        endcase
        if (op_r) begin
            m   = 10'(dh) * 10'd100 + 10'(dt) * 10'd10 + 10'(du);
            neg = idx_ok_r ? (neg2_r | sgn_r) : sgn_r;
        end else begin
            m   = idx_ok_r ? 10'(digit) : 10'd0;
            neg = sgn_r;
        end
        // Negating a zero magnitude yields zero, so no negative-zero case exists.
        res = neg ? 11'(-{1'b0, m}) : {1'b0, m};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= 1'b0;
            sgn_r    <= 1'b0;
            neg2_r   <= 1'b0;
            idx_ok_r <= 1'b0;
            idx_r    <= 2'd0;
            v_r      <= 4'd0;
            mag      <= 10'd0;
            h        <= 4'd0;
            t        <= 4'd0;
            u        <= 4'd0;
            done     <= 1'b0;
            out      <= 11'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r     <= op;
                        sgn_r    <= acc[10];
                        neg2_r   <= arg2[10];
                        idx_ok_r <= idx_ok_load;
                        idx_r    <= arg1[1:0];
                        v_r      <= v_load;
                        mag      <= mag_load;
                        h        <= 4'd0;
                        t        <= 4'd0;
                        u        <= 4'd0;
                    end
                end
                HUND: begin
                    if (mag >= 10'd100) begin
                        mag <= mag - 10'd100;
                        h   <= h + 4'd1;
                    end
                end
                TENS: begin
                    if (mag >= 10'd10) begin
                        mag <= mag - 10'd10;
                        t   <= t + 4'd1;
                    end else begin
                        u <= mag[3:0];
                    end
                end
                FINISH: begin
                    out  <= res;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_unit.sv
// tb/tb_digit_unit.sv - table-driven self-checking bench for digit_unit
module tb_digit_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [10:0] acc = 11'd0;
    logic [10:0] arg1 = 11'd0;
    logic [10:0] arg2 = 11'd0;
    logic        busy, done;
    logic [10:0] out;

    int checks = 0;
    int errors = 0;

    digit_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .acc(acc),
        .arg1(arg1), .arg2(arg2), .busy(busy), .done(done), .out(out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic op;
        int   acc;
        int   a1;
        int   a2;
        int   exp_out;
        int   exp_lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic o, input int a, input int a1, input int a2);
        op   = o;
        acc  = 11'(a);
        arg1 = 11'(a1);
        arg2 = 11'(a2);
    endtask

    // Waits for done after an accepting edge; lat counts edges up to the done edge.
    task automatic wait_done(output int lat);
        lat = 99;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 99) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic o, input int a, input int a1, input int a2,
                          output int res, output int lat);
        @(negedge clk);
        drive(o, a, a1, a2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drive(~o, 11'h2AA, 11'h155, 11'h3FF);
        check("busy_rise", int'(busy), 1);
        wait_done(lat);
        res = int'($signed(out));
        check("busy_fall", int'(busy), 0);
        @(posedge clk);
        #1;
        check("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        int res, lat, ndone, held;

        vecs[0]  = '{1'b0,   345,  0,   0,    5, 10};
        vecs[1]  = '{1'b0,   345,  1,   0,    4, 10};
        vecs[2]  = '{1'b0,   345,  2,   0,    3, 10};
        vecs[3]  = '{1'b0,  -702,  2,   0,   -7, 10};
        vecs[4]  = '{1'b0,  -702,  3,   0,    0, 10};
        vecs[5]  = '{1'b0,  -702, -1,   0,    0, 10};
        vecs[6]  = '{1'b1,   345,  1,   9,  395, 10};
        vecs[7]  = '{1'b1,  -345,  0,  12, -349, 10};
        vecs[8]  = '{1'b1,   345,  2,  -1, -145, 10};
        vecs[9]  = '{1'b1,     0,  0,   0,    0,  3};
        vecs[10] = '{1'b1, -1024,  5,   0, -999, 21};
        vecs[11] = '{1'b1,   999,  2,   0,   99, 21};
        vecs[12] = '{1'b0,  1000,  0,   0,    9, 21};
        vecs[13] = '{1'b1,     5,  0,  -3,   -3,  3};
        vecs[14] = '{1'b1,   -10,  1,   0,    0,  4};
        vecs[15] = '{1'b1,   123,  7,   4,  123,  6};

        #12;
        check("reset_out", int'(out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].acc, vecs[i].a1, vecs[i].a2, res, lat);
            check($sformatf("vec%0d_out", i), res, vecs[i].exp_out);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
        end

        // Abort mid-operation: out must clear and no done may follow.
        run_op(1'b0, 345, 0, 0, res, lat);
        check("pre_abort_out", res, 5);
        @(negedge clk);
        drive(1'b0, 999, 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_out", int'(out), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_out_held", int'(out), 0);
        run_op(1'b0, 999, 1, 0, res, lat);
        check("post_abort_out", res, 9);
        check("post_abort_lat", lat, 21);

        // A start pulse during busy must be ignored entirely.
        @(negedge clk);
        drive(1'b0, 345, 0, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        held = int'($signed(out));
        repeat (2) @(negedge clk);
        drive(1'b1, 999, 2, 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("out_held_busy", int'($signed(out)), held);
        ndone = 0;
        lat = 99;
        for (int i = 3; i <= 35; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (lat == 99) lat = i;
            end
        end
        check("ignored_start_out", int'($signed(out)), 5);
        check("ignored_start_lat", lat, 10);
        check("ignored_start_ndone", ndone, 1);

        // Back-to-back: start held high across done launches the second op.
        @(negedge clk);
        drive(1'b0, 345, 1, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(lat);
        check("b2b_first_out", int'($signed(out)), 4);
        check("b2b_first_lat", lat, 10);
        drive(1'b0, -702, 2, 0);
        @(posedge clk);
        #1;
        check("b2b_busy_reassert", int'(busy), 1);
        start = 1'b0;
        wait_done(lat);
        check("b2b_second_out", int'($signed(out)), -7);
        check("b2b_second_lat", lat, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
